// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU: accept, one EXEC cycle, held response.
// Latency: accept edge t -> rsp_valid from edge t+1; while a response is held, no new request is granted.
module alu_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
  } req_t;

  localparam logic [3:0] OP_LAST = 4'd10;

  state_t state;
  logic   prio;
  logic   grant;
  logic   idle;
  logic   accept;
  logic   illegal;
  req_t   req0_dat;
  req_t   req1_dat;
  req_t   sel_dat;

  assign req0_dat = {req0_a, req0_b, req0_op};
  assign req1_dat = {req1_a, req1_b, req1_op};

  // prio only breaks ties; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign idle       = (state == IDLE) && !rst;
  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign sel_dat    = grant ? req1_dat : req0_dat;
  assign illegal    = (alu_op > OP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= sel_dat.a;
            alu_b  <= sel_dat.b;
            alu_op <= sel_dat.op;
            rsp_id <= grant;
            prio   <= ~grant;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes report a zero result regardless of what the ALU drives.
          rsp_result <= illegal ? '0 : alu_result;
          rsp_err    <= illegal;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) !(req0_ready && req1_ready));
  a_ready_idle:   assert property (@(posedge clk) (req0_ready || req1_ready) |-> (state == IDLE));
  a_rsp_hold:     assert property (@(posedge clk) disable iff (rst)
                                   (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result)
                                                                  && $stable(rsp_id) && $stable(rsp_err)));

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: local ALU model on the alu_* bus, response scoreboard fed by the stimulus.
module tb_alu_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
  logic [3:0] alu_a, alu_b, alu_op, alu_result;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [3:0] rsp_result;

  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  alu_rr_arbiter #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Illegal opcodes produce junk so the arbiter's zeroing is visible.
  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ~a;
      4'd5:    return ~b;
      4'd6:    return a ^ b;
      4'd7:    return a <<< 1;
      4'd8:    return 4'($signed(a) >>> 1);
      4'd9:    return a << 1;
      4'd10:   return a >> 1;
      default: return 4'h9;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [3:0] res, input logic err);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int which);
    bit done = 0;
    #1;
    for (int i = 0; i < 60 && !done; i++) begin
      if ((which == 0 && req0_ready) || (which == 1 && req1_ready)) done = 1;
      else step();
    end
    if (!done) check("ready_timeout", 32'(which), 32'hFFFF);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!busy && !rsp_valid) done = 1;
      else step();
    end
    if (!done) check("idle_timeout", 32'(busy), 32'(0));
  endtask

  // Response monitor: runs after the driver has settled each low phase.
  always begin
    @(negedge clk);
    #3;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_id), 32'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", 32'(rsp_result), 32'(e.res));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3; req0_op = 4'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 4'd0;
    rsp_ready = 1'b1;

    repeat (2) begin
      @(posedge clk); #1;
      check("rst_ready0", 32'(req0_ready), 32'(0));
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
    end

    // Single add, 5+3.
    step();
    rst = 1'b0;
    q.push_back(mk(1'b0, 4'h8, 1'b0));
    #1;
    check("single_ready0", 32'(req0_ready), 32'(1));
    check("single_ready1", 32'(req1_ready), 32'(0));
    @(posedge clk); #1;
    check("acc_busy", 32'(busy), 32'(1));
    check("acc_rsp_valid", 32'(rsp_valid), 32'(0));
    check("acc_ready0_low", 32'(req0_ready), 32'(0));
    req0_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_rsp_valid", 32'(rsp_valid), 32'(1));
    wait_idle();

    // Both valid: prio is 1 after the req0 op, so grants run 1,0,1,0.
    step();
    req0_a = 4'd2; req0_b = 4'd3; req0_op = 4'd1;
    req1_a = 4'hA; req1_b = 4'h5; req1_op = 4'd6;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(mk(i[0] ? 1'b0 : 1'b1, 4'hF, 1'b0));
    #1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      if (req0_ready || req1_ready) begin
        check("alt_onehot", 32'(req0_ready && req1_ready), 32'(0));
        check("alt_grant", 32'(req1_ready), 32'(n % 2 == 0));
        n++;
      end
      if (n < 4) step();
    end
    check("alt_count", 32'(n), 32'(4));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Back-pressure with req1 waiting (illegal op queued behind it).
    step();
    rsp_ready = 1'b0;
    req0_a = 4'd1; req0_b = 4'd1; req0_op = 4'd0; req0_valid = 1'b1;
    q.push_back(mk(1'b0, 4'h2, 1'b0));
    wait_ready(0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_a = 4'h3; req1_b = 4'h0; req1_op = 4'd12; req1_valid = 1'b1;
    q.push_back(mk(1'b1, 4'h0, 1'b1));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid) seen = 1;
      else step();
    end
    check("bp_rsp_seen", 32'(seen), 32'(1));
    repeat (5) begin
      step();
      check("bp_valid", 32'(rsp_valid), 32'(1));
      check("bp_result", 32'(rsp_result), 32'h2);
      check("bp_id", 32'(rsp_id), 32'(0));
      check("bp_req1_ready", 32'(req1_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(rsp_valid), 32'(0));
    check("bp_req1_granted", 32'(req1_ready), 32'(1));
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Legal not-A after the illegal op.
    step();
    req1_a = 4'h3; req1_b = 4'h0; req1_op = 4'd4; req1_valid = 1'b1;
    q.push_back(mk(1'b1, 4'hC, 1'b0));
    wait_ready(1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Reset while EXEC: transaction dropped, prio back to 0.
    step();
    req0_a = 4'd7; req0_b = 4'd1; req0_op = 4'd0; req0_valid = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    check("exec_busy", 32'(busy), 32'(1));
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("exec_rst_busy", 32'(busy), 32'(0));
    check("exec_rst_valid", 32'(rsp_valid), 32'(0));
    step();
    rst = 1'b0;
    repeat (6) begin
      step();
      check("exec_no_rsp", 32'(rsp_valid), 32'(0));
    end
    req0_a = 4'd1; req0_b = 4'd2; req0_op = 4'd3; req0_valid = 1'b1;
    req1_a = 4'd4; req1_b = 4'd4; req1_op = 4'd1; req1_valid = 1'b1;
    q.push_back(mk(1'b0, 4'h3, 1'b0));
    q.push_back(mk(1'b1, 4'h0, 1'b0));
    #1;
    check("post_rst_ready0", 32'(req0_ready), 32'(1));
    check("post_rst_ready1", 32'(req1_ready), 32'(0));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_ready(1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();
    step();

    check("queue_empty", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
